// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl_pkg                                                      |
// | Shared sequencer state encoding and pipeline-control bundle.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hazard_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      run      = 2'd0,
      stall    = 2'd1,
      redirect = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic pc_ld;
      logic if_id_ld;
      logic id_ex_ld;
      logic ex_mem_ld;
      logic mem_wb_ld;
      logic if_id_flush;
      logic id_ex_flush;
      logic redirect_sel;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t C_CTRL_NORMAL       = pipe_ctrl_t'(8'b11111_000);
   localparam pipe_ctrl_t C_CTRL_FREEZE       = pipe_ctrl_t'(8'b00000_000);
   localparam pipe_ctrl_t C_CTRL_LOAD_USE     = pipe_ctrl_t'(8'b00111_010);
   localparam pipe_ctrl_t C_CTRL_REDIRECT_RUN = pipe_ctrl_t'(8'b11111_110);
   localparam pipe_ctrl_t C_CTRL_REDIRECT_LAT = pipe_ctrl_t'(8'b11111_111);

   function automatic logic any_frozen(input pipe_ctrl_t c);
      return ~(c.pc_ld & c.if_id_ld & c.id_ex_ld & c.ex_mem_ld & c.mem_wb_ld);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Up-counter that sticks at all-ones instead of wrapping.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !(&count_q)) begin
         count_d = count_q + C_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl                                                          |
// | Per-cycle load/flush sequencer for the 5-stage rv32i pipeline.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           IF_ID_rs1_i,
   input  logic [4:0]           IF_ID_rs2_i,
   input  logic [4:0]           ID_EX_rd_i,
   input  logic                 ID_EX_mem_read_i,
   input  logic                 imem_read_i,
   input  logic                 imem_resp_i,
   input  logic                 dmem_req_i,
   input  logic                 dmem_resp_i,
   input  logic                 EX_redirect_i,
   output logic                 pc_ld_o,
   output logic                 IF_ID_ld_o,
   output logic                 ID_EX_ld_o,
   output logic                 EX_MEM_ld_o,
   output logic                 MEM_WB_ld_o,
   output logic                 IF_ID_flush_o,
   output logic                 ID_EX_flush_o,
   output logic                 redirect_sel_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);

   hazard_state_t state_q, state_d;
   logic          pending_q, pending_d;
   logic          discard_q, discard_d;

   pipe_ctrl_t    ctrl;
   logic          redirect_applied;
   logic          imem_miss;
   logic          mem_stall;
   logic          load_use;

   assign imem_miss = imem_read_i & ~imem_resp_i;
   assign mem_stall = imem_miss | (dmem_req_i & ~dmem_resp_i);
   assign load_use  = ID_EX_mem_read_i & (ID_EX_rd_i != 5'd0) &
                      ((ID_EX_rd_i == IF_ID_rs1_i) | (ID_EX_rd_i == IF_ID_rs2_i));

   always_comb begin
      state_d          = state_q;
      pending_d        = pending_q;
      discard_d        = discard_q;
      ctrl             = C_CTRL_NORMAL;
      redirect_applied = 1'b0;

      unique case (state_q)
         redirect: begin
            // Latched redirect always completes; a fresh miss is honoured next cycle.
            ctrl             = C_CTRL_REDIRECT_LAT;
            redirect_applied = 1'b1;
            pending_d        = 1'b0;
            discard_d        = 1'b0;
            state_d          = mem_stall ? stall : run;
         end
         run, stall: begin
            if (mem_stall) begin
               ctrl    = C_CTRL_FREEZE;
               state_d = stall;
               if (EX_redirect_i) begin
                  pending_d = 1'b1;
                  if (imem_miss) begin
                     discard_d = 1'b1;
                  end
               end
            end else if ((state_q == stall) && pending_q) begin
               // Release cycle: hold the pipe, soak up the stale fetch as a NOP.
               ctrl             = C_CTRL_FREEZE;
               ctrl.if_id_ld    = discard_q;
               ctrl.if_id_flush = discard_q;
               state_d          = redirect;
            end else begin
               state_d = run;
               if (EX_redirect_i) begin
                  ctrl             = C_CTRL_REDIRECT_RUN;
                  redirect_applied = 1'b1;
               end else if (load_use) begin
                  ctrl = C_CTRL_LOAD_USE;
               end
            end
         end
         default: begin
            state_d   = run;
            pending_d = 1'b0;
            discard_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= run;
         pending_q <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         discard_q <= discard_d;
      end
   end

   assign pc_ld_o        = ctrl.pc_ld;
   assign IF_ID_ld_o     = ctrl.if_id_ld;
   assign ID_EX_ld_o     = ctrl.id_ex_ld;
   assign EX_MEM_ld_o    = ctrl.ex_mem_ld;
   assign MEM_WB_ld_o    = ctrl.mem_wb_ld;
   assign IF_ID_flush_o  = ctrl.if_id_flush;
   assign ID_EX_flush_o  = ctrl.id_ex_flush;
   assign redirect_sel_o = ctrl.redirect_sel;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (any_frozen(ctrl)),
      .count_o (stall_cnt_o)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (redirect_applied),
      .count_o (flush_cnt_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_stall_ctrl                                                       |
// | Directed self-checking bench for the pipeline sequencer.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_stall_ctrl;

   localparam int CW = 4;

   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, redirect_sel}
   localparam logic [7:0] NORMAL   = 8'hF8;
   localparam logic [7:0] FREEZE   = 8'h00;
   localparam logic [7:0] LOADUSE  = 8'h3A;
   localparam logic [7:0] REDIRRUN = 8'hFE;
   localparam logic [7:0] REDIRLAT = 8'hFF;
   localparam logic [7:0] RELDISC  = 8'h44;

   logic clk, rst;
   logic [4:0] rs1, rs2, rd;
   logic mem_read, imem_read, imem_resp, dmem_req, dmem_resp, ex_redirect;
   logic pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_flush, id_ex_flush, redirect_sel;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [7:0] ctrl;

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_stall = '0;
   logic [CW-1:0] exp_flush = '0;

   assign ctrl = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_flush, id_ex_flush, redirect_sel};

   hazard_stall_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .IF_ID_rs1_i      (rs1),
      .IF_ID_rs2_i      (rs2),
      .ID_EX_rd_i       (rd),
      .ID_EX_mem_read_i (mem_read),
      .imem_read_i      (imem_read),
      .imem_resp_i      (imem_resp),
      .dmem_req_i       (dmem_req),
      .dmem_resp_i      (dmem_resp),
      .EX_redirect_i    (ex_redirect),
      .pc_ld_o          (pc_ld),
      .IF_ID_ld_o       (if_id_ld),
      .ID_EX_ld_o       (id_ex_ld),
      .EX_MEM_ld_o      (ex_mem_ld),
      .MEM_WB_ld_o      (mem_wb_ld),
      .IF_ID_flush_o    (if_id_flush),
      .ID_EX_flush_o    (id_ex_flush),
      .redirect_sel_o   (redirect_sel),
      .stall_cnt_o      (stall_cnt),
      .flush_cnt_o      (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; mem_read = 1'b0;
      imem_read = 1'b0; imem_resp = 1'b0;
      dmem_req = 1'b0; dmem_resp = 1'b0; ex_redirect = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL reset_ctrl got %h want %h", ctrl, NORMAL); end
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); end
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state got %h want 0", dut.state_q); end
      rst = 1'b0;
   endtask

   task automatic test_load_use();
      next_cycle();
      mem_read = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
      @(negedge clk);
      checks++;
      if (ctrl !== LOADUSE) begin errors++; $display("FAIL load_use_rs2 got %h want %h", ctrl, LOADUSE); end
      exp_stall = exp_stall + 1'b1;
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL load_use_after got %h want %h", ctrl, NORMAL); end
      checks++;
      if (stall_cnt !== exp_stall) begin errors++; $display("FAIL load_use_cnt got %0d want %0d", stall_cnt, exp_stall); end
      next_cycle();
      mem_read = 1'b1; rd = 5'd9; rs1 = 5'd9; rs2 = 5'd0;
      @(negedge clk);
      checks++;
      if (ctrl !== LOADUSE) begin errors++; $display("FAIL load_use_rs1 got %h want %h", ctrl, LOADUSE); end
      exp_stall = exp_stall + 1'b1;
      next_cycle();
      mem_read = 1'b0; rd = 5'd9; rs1 = 5'd9;
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL not_load got %h want %h", ctrl, NORMAL); end
   endtask

   task automatic test_x0();
      next_cycle();
      mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd7;
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL x0_no_hazard got %h want %h", ctrl, NORMAL); end
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall) begin errors++; $display("FAIL x0_cnt got %0d want %0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_dmem_stall();
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         dmem_req = 1'b1; dmem_resp = 1'b0;
         mem_read = 1'b1; rd = 5'd4; rs1 = 5'd4;
         @(negedge clk);
         checks++;
         if (ctrl !== FREEZE) begin errors++; $display("FAIL dmem_freeze[%0d] got %h want %h", i, ctrl, FREEZE); end
         exp_stall = exp_stall + 1'b1;
      end
      checks++;
      if (dut.state_q !== 2'd1) begin errors++; $display("FAIL dmem_state got %h want 1", dut.state_q); end
      next_cycle();
      dmem_resp = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL dmem_release got %h want %h", ctrl, NORMAL); end
      checks++;
      if (stall_cnt !== exp_stall) begin errors++; $display("FAIL dmem_cnt got %0d want %0d", stall_cnt, exp_stall); end
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL dmem_run got %h want 0", dut.state_q); end
   endtask

   task automatic test_redirect_imem_miss();
      logic [7:0] want [3];
      want[0] = FREEZE; want[1] = FREEZE; want[2] = RELDISC;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         imem_read = 1'b1; imem_resp = (i == 2); ex_redirect = 1'b1;
         @(negedge clk);
         checks++;
         if (ctrl !== want[i]) begin errors++; $display("FAIL imiss_redir[%0d] got %h want %h", i, ctrl, want[i]); end
         exp_stall = exp_stall + 1'b1;
      end
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (ctrl !== REDIRLAT) begin errors++; $display("FAIL imiss_redirect_cycle got %h want %h", ctrl, REDIRLAT); end
      exp_flush = exp_flush + 1'b1;
      next_cycle();
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL imiss_after got %h want %h", ctrl, NORMAL); end
      checks++;
      if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
         errors++; $display("FAIL imiss_cnt got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
      end
   endtask

   task automatic test_redirect_load_use();
      next_cycle();
      ex_redirect = 1'b1; mem_read = 1'b1; rd = 5'd6; rs1 = 5'd6;
      @(negedge clk);
      checks++;
      if (ctrl !== REDIRRUN) begin errors++; $display("FAIL redir_beats_lu got %h want %h", ctrl, REDIRRUN); end
      exp_flush = exp_flush + 1'b1;
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
         errors++; $display("FAIL redir_lu_cnt got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] want [5];
      want[0] = FREEZE; want[1] = FREEZE; want[2] = REDIRLAT; want[3] = FREEZE; want[4] = NORMAL;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         set_idle();
         dmem_req    = 1'b1;
         dmem_resp   = (i == 1) || (i == 4);
         ex_redirect = (i < 2);
         @(negedge clk);
         checks++;
         if (ctrl !== want[i]) begin errors++; $display("FAIL b2b[%0d] got %h want %h", i, ctrl, want[i]); end
         if (want[i] == FREEZE) exp_stall = exp_stall + 1'b1;
      end
      exp_flush = exp_flush + 1'b1;
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
         errors++; $display("FAIL b2b_cnt got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
      end
   endtask

   task automatic test_reset_mid_stall();
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         dmem_req = 1'b1; dmem_resp = 1'b0; ex_redirect = 1'b1;
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      set_idle();
      #1;
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL async_rst_state got %h want 0", dut.state_q); end
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL async_rst_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); end
      exp_stall = '0;
      exp_flush = '0;
      @(negedge clk);
      rst = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL rst_no_redirect got %h want %h", ctrl, NORMAL); end
      checks++;
      if (flush_cnt !== '0) begin errors++; $display("FAIL rst_flush_cnt got %0d want 0", flush_cnt); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 17; i++) begin
         next_cycle();
         dmem_req = 1'b1; dmem_resp = 1'b0;
         @(negedge clk);
         if (i == 15) begin
            checks++;
            if (stall_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL sat_reach got %h want %h", stall_cnt, {CW{1'b1}}); end
         end
      end
      next_cycle();
      set_idle();
      @(negedge clk);
      checks++;
      if (stall_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL sat_hold got %h want %h", stall_cnt, {CW{1'b1}}); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_x0();
      test_dmem_stall();
      test_redirect_imem_miss();
      test_redirect_load_use();
      test_back_to_back();
      test_reset_mid_stall();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
